// File: rtl/neurosync_pkg.sv
// -----------------------------------------------------------------------------
// neurosync_pkg
//   Shared definitions for the NeuroSync round controller.
//   - state_t : FSM state encoding. The numeric values appear on db_estado_o,
//               so they must stay fixed.
//   - clog2w  : index width helper. It returns max(1, ceil(log2(n))), so a
//               single-entry dimension still gets a 1-bit index.
// -----------------------------------------------------------------------------
package neurosync_pkg;

   typedef enum logic [2:0] {
      INICIAL = 3'd0,
      PREPARA = 3'd1,
      MOSTRA  = 3'd2,
      ESPERA  = 3'd3,
      AVALIA  = 3'd4,
      PROXIMA = 3'd5,
      FIM     = 3'd6
   } state_t;

   function automatic int clog2w(input int n);
      int w;
      w = 1;
      // The loop stops at bit 30 so that 1 << i stays positive.
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/neurosync_player_slot.sv
// -----------------------------------------------------------------------------
// neurosync_player_slot
//   Per-player answer logic: rising-edge detection on the player's raw
//   buttons, the answer lock, the answer flag, the correctness flag and the
//   saturating score.
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   botoes_i        raw option buttons of this player
//   gabarito_i      correct option of the current question
//   clear_score_i   zero the score (new game)
//   clear_round_i   drop the lock and answer flag (new game / new question)
//   window_i        answer window is open
//   eval_i          evaluation cycle: add a point when the answer is correct
//   show_i          acertou_o is meaningful (evaluation/advance cycles)
//   respondeu_o     player has locked an answer
//   acertou_o       locked answer matches gabarito_i (gated by show_i)
//   pontos_o        score
// -----------------------------------------------------------------------------
module neurosync_player_slot
   import neurosync_pkg::*;
#(
   parameter  int N_OPTIONS = 4,
   parameter  int SCORE_W   = 4,
   localparam int OW        = clog2w(N_OPTIONS)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [N_OPTIONS-1:0] botoes_i,
   input  logic [OW-1:0]        gabarito_i,
   input  logic                 clear_score_i,
   input  logic                 clear_round_i,
   input  logic                 window_i,
   input  logic                 eval_i,
   input  logic                 show_i,
   output logic                 respondeu_o,
   output logic                 acertou_o,
   output logic [SCORE_W-1:0]   pontos_o
);

   logic [N_OPTIONS-1:0] sync_q;
   logic [N_OPTIONS-1:0] prev_q;
   logic [N_OPTIONS-1:0] pulse;
   logic [OW-1:0]        lock_q, lock_d;
   logic [OW-1:0]        pick;
   logic                 resp_q, resp_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic                 hit;

   assign pulse = sync_q & ~prev_q;

   // Index of the pulsing option. This value is used only when exactly one
   // pulse is active, so the priority among several pulses does not matter.
   always_comb begin
      pick = '0;
      for (int k = 0; k < N_OPTIONS; k++) begin
         if (pulse[k]) pick = OW'(k);
      end
   end

   assign hit = resp_q & (lock_q == gabarito_i);

   always_comb begin
      lock_d  = lock_q;
      resp_d  = resp_q;
      score_d = score_q;
      if (clear_round_i) begin
         lock_d = '0;
         resp_d = 1'b0;
      end else if (window_i && !resp_q && $onehot(pulse)) begin
         // First clean single press wins. Simultaneous presses are treated
         // as ambiguous and do not lock.
         lock_d = pick;
         resp_d = 1'b1;
      end
      if (clear_score_i) begin
         score_d = '0;
      end else if (eval_i && hit && (score_q != {SCORE_W{1'b1}})) begin
         score_d = score_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= '0;
         prev_q  <= '0;
         lock_q  <= '0;
         resp_q  <= 1'b0;
         score_q <= '0;
      end else begin
         sync_q  <= botoes_i;
         prev_q  <= sync_q;
         lock_q  <= lock_d;
         resp_q  <= resp_d;
         score_q <= score_d;
      end
   end

   assign respondeu_o = resp_q;
   assign acertou_o   = show_i & hit;
   assign pontos_o    = score_q;

endmodule

// File: rtl/neurosync_round_controller.sv
// -----------------------------------------------------------------------------
// neurosync_round_controller
//   Sequences the questions of a NeuroSync multiplayer game. For each
//   question it opens a timed answer window, scores the locked answers and,
//   after the last question, reports the winner.
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   jogar_i            raw level; a rising edge starts or restarts a game
//   confirma_i         raw level; a rising edge closes the answer window early
//   botoes_i           raw buttons; player p option k at bit p*N_OPTIONS+k
//   gabarito_i         correct option read from the ROM (1-cycle latency)
//   addr_pergunta_o    current question index (ROM address)
//   respondeu_o        per-player "answer locked" flags
//   acertou_o          per-player "answer correct" flags (AVALIA/PROXIMA)
//   pontos_o           packed scores, player p at [p*SCORE_W +: SCORE_W]
//   vencedor_o         lowest-index top scorer (valid in FIM)
//   empate_o           more than one player holds the top score (valid in FIM)
//   jogando_o          round in progress (MOSTRA..PROXIMA)
//   fim_o              game over
//   db_estado_o        FSM state encoding
// -----------------------------------------------------------------------------
module neurosync_round_controller
   import neurosync_pkg::*;
#(
   parameter  int N_PLAYERS      = 2,
   parameter  int N_OPTIONS      = 4,
   parameter  int N_QUESTIONS    = 8,
   parameter  int TIMEOUT_CYCLES = 50_000_000,
   parameter  int SCORE_W        = 4,
   localparam int PW             = clog2w(N_PLAYERS),
   localparam int OW             = clog2w(N_OPTIONS),
   localparam int AW             = clog2w(N_QUESTIONS),
   localparam int TW             = clog2w(TIMEOUT_CYCLES)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         jogar_i,
   input  logic                         confirma_i,
   input  logic [N_PLAYERS*N_OPTIONS-1:0] botoes_i,
   input  logic [OW-1:0]                gabarito_i,
   output logic [AW-1:0]                addr_pergunta_o,
   output logic [N_PLAYERS-1:0]         respondeu_o,
   output logic [N_PLAYERS-1:0]         acertou_o,
   output logic [N_PLAYERS*SCORE_W-1:0] pontos_o,
   output logic [PW-1:0]                vencedor_o,
   output logic                         empate_o,
   output logic                         jogando_o,
   output logic                         fim_o,
   output logic [2:0]                   db_estado_o
);

   state_t        state_q;
   logic [TW-1:0] timer_q;
   logic [AW-1:0] addr_q;
   logic [PW-1:0] vencedor_q;
   logic          empate_q;

   logic jogar_q, jogar_prev_q, conf_q, conf_prev_q;
   logic jogar_pulse, conf_pulse;

   logic [SCORE_W-1:0] score_w [N_PLAYERS];
   logic [PW-1:0]      best_idx;
   logic [SCORE_W-1:0] best_score;
   logic               tie;
   logic               all_resp;
   logic               last_q;

   // Registered copies of the control inputs, with rising-edge pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         jogar_q      <= 1'b0;
         jogar_prev_q <= 1'b0;
         conf_q       <= 1'b0;
         conf_prev_q  <= 1'b0;
      end else begin
         jogar_q      <= jogar_i;
         jogar_prev_q <= jogar_q;
         conf_q       <= confirma_i;
         conf_prev_q  <= conf_q;
      end
   end

   assign jogar_pulse = jogar_q & ~jogar_prev_q;
   assign conf_pulse  = conf_q & ~conf_prev_q;

   genvar gi;
   generate
      for (gi = 0; gi < N_PLAYERS; gi++) begin : g_slot
         neurosync_player_slot #(
            .N_OPTIONS (N_OPTIONS),
            .SCORE_W   (SCORE_W)
         ) u_slot (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .botoes_i      (botoes_i[gi*N_OPTIONS +: N_OPTIONS]),
            .gabarito_i    (gabarito_i),
            .clear_score_i (state_q == PREPARA),
            .clear_round_i ((state_q == PREPARA) || (state_q == MOSTRA)),
            .window_i      (state_q == ESPERA),
            .eval_i        (state_q == AVALIA),
            .show_i        ((state_q == AVALIA) || (state_q == PROXIMA)),
            .respondeu_o   (respondeu_o[gi]),
            .acertou_o     (acertou_o[gi]),
            .pontos_o      (score_w[gi])
         );
         assign pontos_o[gi*SCORE_W +: SCORE_W] = score_w[gi];
      end
   endgenerate

   // Winner reduction. A strictly greater score takes the lead and clears
   // the tie flag. An equal score keeps the lower index and marks a tie.
   always_comb begin
      best_idx   = '0;
      best_score = score_w[0];
      tie        = 1'b0;
      for (int p = 1; p < N_PLAYERS; p++) begin
         if (score_w[p] > best_score) begin
            best_score = score_w[p];
            best_idx   = PW'(p);
            tie        = 1'b0;
         end else if (score_w[p] == best_score) begin
            tie = 1'b1;
         end
      end
   end

   assign all_resp = &respondeu_o;
   assign last_q   = (addr_q == AW'(N_QUESTIONS - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= INICIAL;
         timer_q    <= '0;
         addr_q     <= '0;
         vencedor_q <= '0;
         empate_q   <= 1'b0;
      end else begin
         case (state_q)
            INICIAL: if (jogar_pulse) state_q <= PREPARA;
            PREPARA: begin
               addr_q     <= '0;
               vencedor_q <= '0;
               empate_q   <= 1'b0;
               state_q    <= MOSTRA;
            end
            MOSTRA: begin
               timer_q <= TW'(TIMEOUT_CYCLES - 1);
               state_q <= ESPERA;
            end
            ESPERA: begin
               if (timer_q != '0) timer_q <= timer_q - 1'b1;
               // A lock taken in this same cycle is still registered by the
               // slot, so it is evaluated in AVALIA.
               if (all_resp || (timer_q == '0) || conf_pulse) state_q <= AVALIA;
            end
            AVALIA: state_q <= PROXIMA;
            PROXIMA: begin
               if (last_q) begin
                  // The scores are final here, so the winner can be captured.
                  vencedor_q <= best_idx;
                  empate_q   <= tie;
                  state_q    <= FIM;
               end else begin
                  addr_q  <= addr_q + 1'b1;
                  state_q <= MOSTRA;
               end
            end
            FIM:     if (jogar_pulse) state_q <= PREPARA;
            default: state_q <= INICIAL;
         endcase
      end
   end

   assign addr_pergunta_o = addr_q;
   assign vencedor_o      = vencedor_q;
   assign empate_o        = empate_q;
   assign jogando_o       = (state_q == MOSTRA) || (state_q == ESPERA) ||
                            (state_q == AVALIA) || (state_q == PROXIMA);
   assign fim_o           = (state_q == FIM);
   assign db_estado_o     = state_q;

endmodule

// File: tb/tb_neurosync_round_controller.sv
module tb_neurosync_round_controller;

   localparam int NP = 2, NO = 4, NQ = 8, TO = 20, SW = 3;
   localparam int SMAX = 7;
   localparam logic [2:0] S_INICIAL = 3'd0, S_ESPERA = 3'd3, S_PROXIMA = 3'd5, S_FIM = 3'd6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       jogar = 1'b0;
   logic       confirma = 1'b0;
   logic [7:0] botoes = '0;
   logic [1:0] gabarito;
   logic [2:0] addr;
   logic [1:0] respondeu, acertou;
   logic [5:0] pontos;
   logic       vencedor, empate, jogando, fim;
   logic [2:0] estado;

   logic [1:0] rom [NQ];
   int n_vec = 0;
   int n_fail = 0;
   int sc [2];

   typedef struct {
      int         q;
      logic [1:0] resp;
      logic [1:0] acert;
      int         pts;
      logic       venc;
      logic       emp;
   } exp_t;
   exp_t sb [$];

   neurosync_round_controller #(
      .N_PLAYERS      (NP),
      .N_OPTIONS      (NO),
      .N_QUESTIONS    (NQ),
      .TIMEOUT_CYCLES (TO),
      .SCORE_W        (SW)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .jogar_i         (jogar),
      .confirma_i      (confirma),
      .botoes_i        (botoes),
      .gabarito_i      (gabarito),
      .addr_pergunta_o (addr),
      .respondeu_o     (respondeu),
      .acertou_o       (acertou),
      .pontos_o        (pontos),
      .vencedor_o      (vencedor),
      .empate_o        (empate),
      .jogando_o       (jogando),
      .fim_o           (fim),
      .db_estado_o     (estado)
   );

   always #5 clk = ~clk;

   // Question ROM with one cycle of read latency.
   always @(posedge clk) gabarito <= rom[addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      int n;
      n = 0;
      while (estado !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {29'd0, estado}, {29'd0, s});
   endtask

   task automatic start_game(output int lat);
      int n;
      sc[0] = 0;
      sc[1] = 0;
      jogar = 1'b1;
      @(negedge clk);
      jogar = 1'b0;
      n = 0;
      while (estado !== S_ESPERA && n < 20) begin
         @(negedge clk);
         n++;
      end
      lat = n;
   endtask

   // Push the model's expectation, drive the presses during the answer
   // window, then pop and compare when the DUT reaches PROXIMA.
   task automatic run_question(input int q, input logic [3:0] m0a, input logic [3:0] m1a,
                               input logic [3:0] m0b, input logic [3:0] m1b,
                               input bit conf, input bit jog, output int esp);
      logic [1:0] r, a;
      int         lk [2];
      logic [3:0] ms [4];
      exp_t       e;
      int         n;
      r = '0;
      lk = '{0, 0};
      ms = '{m0a, m1a, m0b, m1b};
      for (int i = 0; i < 4; i++) begin
         int p;
         p = i % 2;
         if (!r[p] && $countones(ms[i]) == 1) begin
            r[p] = 1'b1;
            lk[p] = $clog2(ms[i]);
         end
      end
      for (int p = 0; p < 2; p++) begin
         a[p] = r[p] && (lk[p] == int'(rom[q]));
         sc[p] = (sc[p] + int'(a[p]) > SMAX) ? SMAX : sc[p] + int'(a[p]);
      end
      e = '{q: q, resp: r, acert: a, pts: sc[1] * 8 + sc[0], venc: 1'b0, emp: 1'b0};
      sb.push_back(e);

      wait_state(S_ESPERA, 40, "enter ESPERA");
      chk("addr", {29'd0, addr}, q);
      chk("jogando/fim", {30'd0, jogando, fim}, 32'd2);
      n = 0;
      while (estado === S_ESPERA && n < 100) begin
         case (n)
            0: begin botoes = {m1a, m0a}; confirma = conf; jogar = jog; end
            1: begin botoes = '0; confirma = 1'b0; jogar = 1'b0; end
            2: botoes = {m1b, m0b};
            3: botoes = '0;
            default: ;
         endcase
         n++;
         @(negedge clk);
      end
      botoes = '0;
      confirma = 1'b0;
      jogar = 1'b0;
      esp = n;
      wait_state(S_PROXIMA, 5, "reach PROXIMA");
      e = sb.pop_front();
      chk("respondeu", {30'd0, respondeu}, {30'd0, e.resp});
      chk("acertou", {30'd0, acertou}, {30'd0, e.acert});
      chk("pontos", {26'd0, pontos}, e.pts);
      $display("q%0d gab=%0d respondeu=%b acertou=%b pontos=%0h espera=%0d",
               q, rom[q], respondeu, acertou, pontos, esp);
   endtask

   task automatic check_fim();
      exp_t e;
      e = '{q: -1, resp: 2'b00, acert: 2'b00, pts: sc[1] * 8 + sc[0],
            venc: (sc[1] > sc[0]), emp: (sc[1] == sc[0])};
      sb.push_back(e);
      wait_state(S_FIM, 10, "reach FIM");
      e = sb.pop_front();
      chk("fim pontos", {26'd0, pontos}, e.pts);
      chk("vencedor", {31'd0, vencedor}, {31'd0, e.venc});
      chk("empate", {31'd0, empate}, {31'd0, e.emp});
      chk("fim flags", {30'd0, jogando, fim}, 32'd1);
      $display("game end pontos=%0h vencedor=%0d empate=%0d", pontos, vencedor, empate);
   endtask

   initial begin
      int lat, esp;
      for (int i = 0; i < NQ; i++) rom[i] = 2'd2;

      // Reset state, then confirma while idle must not move the FSM.
      @(negedge clk);
      @(negedge clk);
      chk("reset outputs", {12'd0, addr, respondeu, acertou, pontos, vencedor, empate, jogando, fim, estado}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      confirma = 1'b1;
      @(negedge clk);
      confirma = 1'b0;
      repeat (3) @(negedge clk);
      chk("confirma idle", {29'd0, estado}, {29'd0, S_INICIAL});

      // Game 1: P0 always correct (opt 2), P1 always wrong (opt 1).
      start_game(lat);
      chk("start latency", lat, 3);
      for (int q = 0; q < NQ; q++) run_question(q, 4'b0100, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, esp);
      check_fim();

      // Game 2: timeout, double press, confirma, jogar ignored mid-window.
      rom = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2};
      start_game(lat);
      chk("restart latency", lat, 3);
      run_question(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, esp);
      chk("timeout length", esp, TO);
      run_question(1, 4'b0010, 4'b1001, 4'b0100, 4'b1000, 1'b0, 1'b0, esp);
      run_question(2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, esp);
      chk("confirma exit", esp, 2);
      run_question(3, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1, esp);
      chk("jogar ignored", esp, TO);
      for (int q = 4; q < NQ; q++) run_question(q, 4'b1000, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, esp);
      check_fim();

      // Game 3: both always correct, scores saturate and tie.
      for (int i = 0; i < NQ; i++) rom[i] = 2'(i % 4);
      start_game(lat);
      for (int q = 0; q < NQ; q++) begin
         logic [3:0] m;
         m = 4'b0001 << rom[q];
         run_question(q, m, m, 4'b0000, 4'b0000, 1'b0, 1'b0, esp);
      end
      check_fim();

      // Game 4: reset during the answer window of question index 2.
      start_game(lat);
      run_question(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, esp);
      run_question(1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, esp);
      wait_state(S_ESPERA, 40, "q2 ESPERA");
      chk("abort addr", {29'd0, addr}, 32'd2);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort state", {29'd0, estado}, {29'd0, S_INICIAL});
      chk("abort outputs", {12'd0, addr, respondeu, acertou, pontos, vencedor, empate, jogando, fim, estado}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      start_game(lat);
      chk("post-abort latency", lat, 3);
      chk("post-abort addr", {29'd0, addr}, 32'd0);
      chk("post-abort pontos", {26'd0, pontos}, 32'd0);
      run_question(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, esp);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
